// File: rtl/skew_feeder.sv
// skew_feeder: buffers one DIM x DIM operand tile and streams it
// diagonally skewed into a systolic array's row inputs.
module skew_feeder #(
  parameter int DIM  = 8,
  parameter int BITS = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en,
  input  logic                           wr_en,
  input  logic [$clog2(DIM)-1:0]         wr_row,
  input  logic [DIM-1:0][BITS-1:0]       wr_data,
  input  logic                           start,
  output logic [DIM-1:0][BITS-1:0]       Aout,
  output logic                           busy,
  output logic                           last
);

  localparam int TW = $clog2(2 * DIM);
  localparam logic [TW-1:0] T_LAST = TW'(2 * DIM - 2);

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  state_t                          r_state;
  state_t                          w_state_nxt;
  logic [TW-1:0]                   r_t;
  logic [TW-1:0]                   w_t_nxt;
  logic [DIM-1:0][DIM-1:0][BITS-1:0] r_buf;
  logic [DIM-1:0][BITS-1:0]        r_aout;
  logic [DIM-1:0][BITS-1:0]        w_aout_nxt;
  logic [DIM-1:0][BITS-1:0]        w_beat;
  logic                            r_last;
  logic                            w_last_nxt;
  logic                            w_wr;

  // Row i sees column t-i: one anti-diagonal of the tile per beat.
  always_comb begin
    w_beat = '0;
    for (int i = 0; i < DIM; i++) begin
      for (int j = 0; j < DIM; j++) begin
        if (int'(r_t) == i + j) begin
          w_beat[i] = r_buf[i][j];
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_t_nxt     = r_t;
    w_aout_nxt  = '0;
    w_last_nxt  = 1'b0;
    w_wr        = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_wr    = wr_en;
        w_t_nxt = '0;
        if (start) begin
          w_state_nxt = STREAM;
        end
      end
      STREAM: begin
        w_aout_nxt = w_beat;
        if (r_t == T_LAST) begin
          w_last_nxt  = 1'b1;
          w_state_nxt = IDLE;
          w_t_nxt     = '0;
        end else begin
          w_t_nxt = r_t + TW'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_t     <= '0;
      r_aout  <= '0;
      r_last  <= 1'b0;
    end else if (en) begin
      r_state <= w_state_nxt;
      r_t     <= w_t_nxt;
      r_aout  <= w_aout_nxt;
      r_last  <= w_last_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf <= '0;
    end else if (en && w_wr) begin
      r_buf[wr_row] <= wr_data;
    end
  end

  assign Aout = r_aout;
  assign busy = (r_state == STREAM);
  assign last = r_last;

endmodule

// File: tb/tb_skew_feeder.sv
// tb_skew_feeder: scoreboard bench for skew_feeder, DIM=8 BITS=8.
// Expected beats are built from a bench-side tile copy when start is driven.
module tb_skew_feeder;

  localparam int DIM  = 8;
  localparam int BITS = 8;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     en = 1'b0;
  logic                     wr_en = 1'b0;
  logic                     start = 1'b0;
  logic [2:0]               wr_row = '0;
  logic [DIM-1:0][BITS-1:0] wr_data = '0;
  logic [DIM-1:0][BITS-1:0] Aout;
  logic                     busy;
  logic                     last;

  skew_feeder #(.DIM(DIM), .BITS(BITS)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .wr_en   (wr_en),
    .wr_row  (wr_row),
    .wr_data (wr_data),
    .start   (start),
    .Aout    (Aout),
    .busy    (busy),
    .last    (last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] a;
    logic        b;
    logic        l;
  } exp_t;

  exp_t       sb[$];
  exp_t       cur;
  logic [7:0] mbuf [DIM][DIM];
  int         n_chk  = 0;
  int         n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] beat(input int t);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < DIM; i++) begin
      if (t - i >= 0 && t - i < DIM) begin
        v[i*8 +: 8] = mbuf[i][t-i];
      end
    end
    return v;
  endfunction

  // Called at a negedge: drive, let one posedge pass, check at next negedge.
  task automatic cyc(input logic s, input logic w, input int row,
                     input logic [63:0] d, input logic e,
                     input string tag);
    bit idle;
    idle    = (sb.size() == 0);
    start   = s;
    wr_en   = w;
    wr_row  = 3'(row);
    wr_data = d;
    en      = e;
    if (e && idle && w) begin
      for (int j = 0; j < DIM; j++) mbuf[row][j] = d[j*8 +: 8];
    end
    if (e && idle && s) begin
      sb.push_back('{a: '0, b: 1'b1, l: 1'b0});
      for (int t = 0; t < 2 * DIM - 1; t++) begin
        sb.push_back('{a: beat(t), b: (t < 2 * DIM - 2),
                       l: (t == 2 * DIM - 2)});
      end
    end
    if (e) begin
      cur = (sb.size() > 0) ? sb.pop_front() : exp_t'('0);
    end
    @(negedge clk);
    chk({tag, ".aout"}, Aout, cur.a);
    chk({tag, ".busy"}, 64'(busy), 64'(cur.b));
    chk({tag, ".last"}, 64'(last), 64'(cur.l));
  endtask

  task automatic run(input int n, input string tag);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 0, '0, 1'b1, tag);
  endtask

  function automatic logic [63:0] row_fill(input int i);
    logic [63:0] v;
    for (int j = 0; j < DIM; j++) v[j*8 +: 8] = 8'(8 * i + j - 32);
    return v;
  endfunction

  initial begin
    logic [63:0] edge_row;
    cur = '0;
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) mbuf[i][j] = '0;

    repeat (2) @(negedge clk);
    chk("rst.aout", Aout, '0);
    chk("rst.busy", 64'(busy), 64'(0));
    chk("rst.last", 64'(last), 64'(0));
    rst_n = 1'b1;
    run(2, "idle");

    // Ramp tile, plain 15-beat stream plus idle tail.
    for (int i = 0; i < DIM; i++) cyc(1'b0, 1'b1, i, row_fill(i), 1'b1, "wr");
    cyc(1'b1, 1'b0, 0, '0, 1'b1, "go1");
    run(17, "s1");

    // Freeze for 3 cycles right after beat 5 is visible.
    cyc(1'b1, 1'b0, 0, '0, 1'b1, "go2");
    run(6, "s2a");
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b1, 3, '1, 1'b0, "hold");
    run(11, "s2b");

    // Writes and start during a stream are ignored.
    cyc(1'b1, 1'b0, 0, '0, 1'b1, "go3");
    run(4, "s3a");
    cyc(1'b1, 1'b1, 2, {8{8'h7f}}, 1'b1, "wrbusy");
    run(12, "s3b");
    cyc(1'b1, 1'b0, 0, '0, 1'b1, "go4");
    run(17, "s4");

    // Extremes, written in the same cycle as start.
    for (int j = 0; j < DIM; j++) edge_row[j*8 +: 8] = j[0] ? 8'h7f : 8'h80;
    cyc(1'b0, 1'b1, 7, ~edge_row, 1'b1, "wr7");
    cyc(1'b1, 1'b1, 0, edge_row, 1'b1, "go5");
    run(17, "s5");

    // start held high: back-to-back streams.
    for (int k = 0; k < 20; k++) cyc(1'b1, 1'b0, 0, '0, 1'b1, "hi");
    run(14, "s6");

    // Asynchronous reset at beat 7.
    cyc(1'b1, 1'b0, 0, '0, 1'b1, "go7");
    run(8, "s7");
    #1 rst_n = 1'b0;
    #1;
    chk("arst.aout", Aout, '0);
    chk("arst.busy", 64'(busy), 64'(0));
    chk("arst.last", 64'(last), 64'(0));
    sb.delete();
    cur = '0;
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) mbuf[i][j] = '0;
    @(negedge clk);
    chk("arst2.last", 64'(last), 64'(0));
    rst_n = 1'b1;
    run(2, "post");
    cyc(1'b1, 1'b0, 0, '0, 1'b1, "go8");
    run(17, "s8");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
